// File: rtl/axil_desc_ram.sv
// AXI4-Lite slave backed by a register RAM for scatter-gather descriptors.
// Optional CTRL-word doorbell output enabled by AXIL_DESC_RAM_DOORBELL_EN.
module axil_desc_ram #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0001_0000,
  parameter int                    DEPTH      = 64
) (
  input  logic                    S_AXI_aclk,
  input  logic                    S_AXI_aresetn,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [2:0]              S_AXI_awprot,
  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  output logic [1:0]              S_AXI_bresp,
  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [2:0]              S_AXI_arprot,
  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready
`ifdef AXIL_DESC_RAM_DOORBELL_EN
  ,
  output logic                    doorbell,
  output logic [$clog2(DEPTH)-1:0] doorbell_idx
`endif
);

  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(DEPTH*4-1);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    aw_full;
  logic                    w_full;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    wr_fire;
  logic                    wr_hit;
  logic [IDX_W-1:0]        wr_idx;
  logic                    rd_hit;
  logic [IDX_W-1:0]        rd_idx;
  logic                    unused_prot;

  assign wr_fire = aw_full && w_full;
  assign wr_hit  = (aw_addr & ~OFS_MASK) == BASE_ADDR;
  assign wr_idx  = aw_addr[IDX_W+1:2];
  assign rd_hit  = (S_AXI_araddr & ~OFS_MASK) == BASE_ADDR;
  assign rd_idx  = S_AXI_araddr[IDX_W+1:2];
  assign unused_prot = ^{S_AXI_awprot, S_AXI_arprot};

  // AW and W are captured independently; readies stay low until the B handshake.
  always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
    if (!S_AXI_aresetn) begin
      S_AXI_awready <= 1'b0;
      S_AXI_wready  <= 1'b0;
      S_AXI_bvalid  <= 1'b0;
      S_AXI_bresp   <= RESP_OKAY;
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
    end else begin
      if (!aw_full && !S_AXI_bvalid) S_AXI_awready <= 1'b1;
      if (!w_full && !S_AXI_bvalid)  S_AXI_wready  <= 1'b1;
      if (S_AXI_bvalid && S_AXI_bready) begin
        S_AXI_bvalid  <= 1'b0;
        S_AXI_awready <= 1'b1;
        S_AXI_wready  <= 1'b1;
      end
      if (S_AXI_awvalid && S_AXI_awready) begin
        aw_addr       <= S_AXI_awaddr;
        aw_full       <= 1'b1;
        S_AXI_awready <= 1'b0;
      end
      if (S_AXI_wvalid && S_AXI_wready) begin
        w_data       <= S_AXI_wdata;
        w_strb       <= S_AXI_wstrb;
        w_full       <= 1'b1;
        S_AXI_wready <= 1'b0;
      end
      if (wr_fire) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        S_AXI_bvalid <= 1'b1;
        S_AXI_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge S_AXI_aclk) begin
    if (wr_fire && wr_hit) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (w_strb[b]) mem[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Read data is taken from the RAM before any same-edge write lands.
  always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
    if (!S_AXI_aresetn) begin
      S_AXI_arready <= 1'b0;
      S_AXI_rvalid  <= 1'b0;
      S_AXI_rdata   <= '0;
      S_AXI_rresp   <= RESP_OKAY;
    end else begin
      if (!S_AXI_rvalid) S_AXI_arready <= 1'b1;
      if (S_AXI_rvalid && S_AXI_rready) begin
        S_AXI_rvalid  <= 1'b0;
        S_AXI_arready <= 1'b1;
      end
      if (S_AXI_arvalid && S_AXI_arready) begin
        S_AXI_arready <= 1'b0;
        S_AXI_rvalid  <= 1'b1;
        S_AXI_rdata   <= rd_hit ? mem[rd_idx] : '0;
        S_AXI_rresp   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

`ifdef AXIL_DESC_RAM_DOORBELL_EN
  logic db_hit;
  assign db_hit = wr_fire && wr_hit && ((32'(wr_idx) & 32'hF) == 32'h5);

  // Pulse lines up with the bvalid rising edge of a CTRL-word write.
  always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
    if (!S_AXI_aresetn) begin
      doorbell     <= 1'b0;
      doorbell_idx <= '0;
    end else begin
      doorbell <= db_hit;
      if (db_hit) doorbell_idx <= wr_idx;
    end
  end
`endif

endmodule

// File: tb/tb_axil_desc_ram.sv
// Directed testbench for axil_desc_ram with a transaction-level memory model.
// Doorbell checks are compiled in with AXIL_DESC_RAM_DOORBELL_EN.
module tb_axil_desc_ram;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
`ifdef AXIL_DESC_RAM_DOORBELL_EN
  logic        doorbell;
  logic [5:0]  doorbell_idx;
  int          db_count = 0;
`endif

  axil_desc_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .S_AXI_aclk(aclk), .S_AXI_aresetn(aresetn),
    .S_AXI_awaddr(awaddr), .S_AXI_awprot(awprot), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
    .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
    .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
    .S_AXI_araddr(araddr), .S_AXI_arprot(arprot), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
    .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready)
`ifdef AXIL_DESC_RAM_DOORBELL_EN
    , .doorbell(doorbell), .doorbell_idx(doorbell_idx)
`endif
  );

  always #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [DEPTH];
  logic [1:0]  exp_b [$];
  logic [31:0] exp_rdata [$];
  logic [1:0]  exp_rresp [$];
  logic [1:0]  last_bresp;
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp;

  function automatic bit model_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(DEPTH*4));
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=timeout required=handshake", name);
  endtask

  // Response checker: every cycle a response is valid it must match the oldest expectation.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (bvalid) begin
        if (exp_b.size() == 0) timeout_fail("unexpected_bvalid");
        else begin
          checkOutput("bresp", 32'(bresp), 32'(exp_b[0]));
          if (bready) begin
            last_bresp = bresp;
            void'(exp_b.pop_front());
          end
        end
      end
      if (rvalid) begin
        if (exp_rdata.size() == 0) timeout_fail("unexpected_rvalid");
        else begin
          checkOutput("rdata", rdata, exp_rdata[0]);
          checkOutput("rresp", 32'(rresp), 32'(exp_rresp[0]));
          if (rready) begin
            last_rdata = rdata;
            last_rresp = rresp;
            void'(exp_rdata.pop_front());
            void'(exp_rresp.pop_front());
          end
        end
      end
    end
  end

`ifdef AXIL_DESC_RAM_DOORBELL_EN
  always @(negedge aclk) if (aresetn && doorbell) db_count++;
`endif

  task automatic drive_aw(input logic [31:0] addr, input int delay);
    bit done = 1'b0;
    repeat (delay) @(posedge aclk);
    if (delay > 0) #1;
    awaddr = addr;
    awvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge aclk);
      if (awready) begin
        @(posedge aclk);
        #1 awvalid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      awvalid = 1'b0;
      timeout_fail("aw_handshake");
    end
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int delay);
    bit done = 1'b0;
    repeat (delay) @(posedge aclk);
    if (delay > 0) #1;
    wdata = data;
    wstrb = strb;
    wvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge aclk);
      if (wready) begin
        @(posedge aclk);
        #1 wvalid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      wvalid = 1'b0;
      timeout_fail("w_handshake");
    end
  endtask

  task automatic drive_ar(input logic [31:0] addr, input int delay);
    bit done = 1'b0;
    repeat (delay) @(posedge aclk);
    if (delay > 0) #1;
    araddr = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge aclk);
      if (arready) begin
        @(posedge aclk);
        #1 arvalid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      arvalid = 1'b0;
      timeout_fail("ar_handshake");
    end
  endtask

  task automatic wait_b();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge aclk);
      if (bvalid && bready) begin
        @(posedge aclk);
        #1 done = 1'b1;
      end
    end
    if (!done) timeout_fail("b_handshake");
  endtask

  task automatic wait_r();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge aclk);
      if (rvalid && rready) begin
        @(posedge aclk);
        #1 done = 1'b1;
      end
    end
    if (!done) timeout_fail("r_handshake");
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    exp_b.push_back(model_hit(addr) ? 2'b00 : 2'b10);
    if (model_hit(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_mem[model_idx(addr)][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_delay, input int w_delay);
    last_bresp = 'x;
    model_write(addr, data, strb);
    fork
      drive_aw(addr, aw_delay);
      drive_w(data, strb, w_delay);
      wait_b();
    join
  endtask

  task automatic axi_read_exp(input logic [31:0] addr, input logic [31:0] edata, input logic [1:0] eresp,
                              input int ar_delay);
    last_rdata = 'x;
    last_rresp = 'x;
    exp_rdata.push_back(edata);
    exp_rresp.push_back(eresp);
    fork
      drive_ar(addr, ar_delay);
      wait_r();
    join
  endtask

  task automatic axi_read(input logic [31:0] addr);
    if (model_hit(addr)) axi_read_exp(addr, model_mem[model_idx(addr)], 2'b00, 0);
    else                 axi_read_exp(addr, 32'h0, 2'b10, 0);
  endtask

  task automatic applyStimulus();
    // Reset values and first edge after release
    repeat (2) @(negedge aclk);
    checkOutput("rst_awready", 32'(awready), 0);
    checkOutput("rst_wready", 32'(wready), 0);
    checkOutput("rst_arready", 32'(arready), 0);
    checkOutput("rst_bvalid", 32'(bvalid), 0);
    checkOutput("rst_rvalid", 32'(rvalid), 0);
    checkOutput("rst_bresp", 32'(bresp), 0);
    checkOutput("rst_rresp", 32'(rresp), 0);
    checkOutput("rst_rdata", rdata, 0);
    aresetn = 1'b1;
    #1 checkOutput("rel_awready_pre", 32'(awready), 0);
    @(negedge aclk);
    checkOutput("rel_awready", 32'(awready), 1);
    checkOutput("rel_wready", 32'(wready), 1);
    checkOutput("rel_arready", 32'(arready), 1);
    @(posedge aclk);
    #1;

    $display("[TB] basic write/read");
    axi_write(32'h0001_0008, 32'hC000_1000, 4'hF, 0, 0);
    checkOutput("t1_bresp", 32'(last_bresp), 0);
    axi_read(32'h0001_0008);
    checkOutput("t1_rdata", last_rdata, 32'hC000_1000);
    checkOutput("t1_rresp", 32'(last_rresp), 0);

    $display("[TB] AW leads W by three cycles");
    model_write(32'h0001_0040, 32'h0001_0040, 4'hF);
    awaddr = 32'h0001_0040; awvalid = 1'b1;
    wdata = 32'h0001_0040; wstrb = 4'hF; wvalid = 1'b0;
    @(negedge aclk);
    checkOutput("t2_awready_idle", 32'(awready), 1);
    @(posedge aclk);
    #1 awvalid = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      checkOutput("t2_awready_wait", 32'(awready), 0);
      checkOutput("t2_bvalid_wait", 32'(bvalid), 0);
      @(posedge aclk);
      #1;
    end
    wvalid = 1'b1;
    @(negedge aclk);
    checkOutput("t2_wready", 32'(wready), 1);
    @(posedge aclk);
    #1 wvalid = 1'b0;
    @(negedge aclk);
    checkOutput("t2_bvalid_capture", 32'(bvalid), 0);
    @(negedge aclk);
    checkOutput("t2_bvalid_next", 32'(bvalid), 1);
    @(negedge aclk);
    checkOutput("t2_bvalid_done", 32'(bvalid), 0);
    checkOutput("t2_awready_back", 32'(awready), 1);
    checkOutput("t2_wready_back", 32'(wready), 1);
    @(posedge aclk);
    #1;
    axi_read(32'h0001_0040);
    checkOutput("t2_rdata", last_rdata, 32'h0001_0040);

    $display("[TB] byte strobes");
    axi_write(32'h0001_0014, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(32'h0001_0014, 32'h1234_5678, 4'b0011, 1, 0);
    axi_read(32'h0001_0014);
    checkOutput("t3_rdata", last_rdata, 32'hFFFF_5678);
    axi_write(32'h0001_0008, 32'hDEAD_BEEF, 4'h0, 0, 2);
    checkOutput("t3_zero_strb_bresp", 32'(last_bresp), 0);
    axi_read(32'h0001_0008);
    checkOutput("t3_zero_strb_rdata", last_rdata, 32'hC000_1000);

    $display("[TB] out-of-window accesses");
    axi_write(32'h0001_0000, 32'h600D_F00D, 4'hF, 0, 0);
    axi_write(32'h0002_0000, 32'hA5A5_A5A5, 4'hF, 0, 0);
    checkOutput("t4_bresp", 32'(last_bresp), 2);
    axi_write(32'h0001_0100, 32'h5A5A_5A5A, 4'hF, 0, 0);
    axi_read(32'h0002_0000);
    checkOutput("t4_rdata", last_rdata, 0);
    checkOutput("t4_rresp", 32'(last_rresp), 2);
    axi_read(32'h0000_FFFC);
    axi_read(32'h0001_0000);
    checkOutput("t4_word0", last_rdata, 32'h600D_F00D);
    axi_read(32'h0001_00FF);

    $display("[TB] bready held low");
    bready = 1'b0;
    model_write(32'h0001_0020, 32'h1111_2222, 4'hF);
    awaddr = 32'h0001_0020; awvalid = 1'b1;
    wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    @(posedge aclk);
    #1 awvalid = 1'b0;
    wvalid = 1'b0;
    @(posedge aclk);
    #1 awaddr = 32'h0001_0024;
    awvalid = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      checkOutput("t5_bvalid_hold", 32'(bvalid), 1);
      checkOutput("t5_awready_hold", 32'(awready), 0);
      checkOutput("t5_wready_hold", 32'(wready), 0);
      @(posedge aclk);
      #1;
    end
    bready = 1'b1;
    @(negedge aclk);
    checkOutput("t5_awready_at_b", 32'(awready), 0);
    @(negedge aclk);
    checkOutput("t5_awready_after_b", 32'(awready), 1);
    checkOutput("t5_bvalid_after_b", 32'(bvalid), 0);
    @(posedge aclk);
    #1 awvalid = 1'b0;
    model_write(32'h0001_0024, 32'h3333_4444, 4'hF);
    fork
      drive_w(32'h3333_4444, 4'hF, 0);
      wait_b();
    join
    axi_read(32'h0001_0020);
    checkOutput("t5_rdata0", last_rdata, 32'h1111_2222);
    axi_read(32'h0001_0024);
    checkOutput("t5_rdata1", last_rdata, 32'h3333_4444);

    $display("[TB] read and write on the same edge");
    fork
      axi_write(32'h0001_0040, 32'h55AA_55AA, 4'hF, 0, 0);
      axi_read_exp(32'h0001_0040, 32'h0001_0040, 2'b00, 1);
    join
    checkOutput("t6_pre_write", last_rdata, 32'h0001_0040);
    axi_read(32'h0001_0040);
    checkOutput("t6_post_write", last_rdata, 32'h55AA_55AA);

`ifdef AXIL_DESC_RAM_DOORBELL_EN
    $display("[TB] doorbell");
    db_count = 0;
    axi_write(32'h0001_0054, 32'h0000_00DB, 4'hF, 0, 0);
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("db_count", 32'(db_count), 1);
    checkOutput("db_idx", 32'(doorbell_idx), 21);
    axi_write(32'h0001_0058, 32'h0000_00DC, 4'hF, 0, 0);
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("db_count_other", 32'(db_count), 1);
    checkOutput("db_idx_hold", 32'(doorbell_idx), 21);
`endif

    $display("[TB] reset with only AW captured");
    axi_write(32'h0001_0030, 32'h7777_8888, 4'hF, 0, 0);
    awaddr = 32'h0001_0030; awvalid = 1'b1;
    @(negedge aclk);
    checkOutput("t7_awready", 32'(awready), 1);
    @(posedge aclk);
    #1 awvalid = 1'b0;
    @(negedge aclk);
    checkOutput("t7_aw_captured", 32'(awready), 0);
    aresetn = 1'b0;
    #1;
    checkOutput("t7_wready_rst", 32'(wready), 0);
    checkOutput("t7_arready_rst", 32'(arready), 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("t7_awready_rel", 32'(awready), 1);
    checkOutput("t7_wready_rel", 32'(wready), 1);
    checkOutput("t7_arready_rel", 32'(arready), 1);
    checkOutput("t7_bvalid_rel", 32'(bvalid), 0);
    checkOutput("t7_rvalid_rel", 32'(rvalid), 0);
    @(posedge aclk);
    #1;
    axi_read(32'h0001_0030);
    checkOutput("t7_word_kept", last_rdata, 32'h7777_8888);
    axi_write(32'h0001_0030, 32'h0BAD_CAFE, 4'b1100, 0, 1);
    axi_read(32'h0001_0030);
    checkOutput("t7_after_write", last_rdata, 32'h0BAD_8888);

    checkOutput("pending_b", 32'(exp_b.size()), 0);
    checkOutput("pending_r", 32'(exp_rdata.size()), 0);
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
